// File: rtl/div_unit_if.sv
// Divider handshake and data bundle between the EX stage / hazard unit and div_unit.
// The master drives the start/kill request and operands; the slave returns stall, ready and results.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             isdivE;
  logic             signeddivE;
  logic             annulE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             div_stall;
  logic             div_ready;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  modport master (
    output isdivE, signeddivE, annulE, srcaE, srcbE,
    input  div_stall, div_ready, div_hi, div_lo
  );

  modport slave (
    input  isdivE, signeddivE, annulE, srcaE, srcbE,
    output div_stall, div_ready, div_hi, div_lo
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (div/divu): one quotient bit per cycle, sign fix-up on completion.
// Quotient goes to div_lo, remainder to div_hi; divide by zero returns all ones / raw dividend.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       stateReg, stateNext;
  logic [CW-1:0]    cntReg;
  logic             signedReg, negAReg, negBReg, zeroReg;
  logic [WIDTH-1:0] divisorReg, quotReg, remReg;
  logic [WIDTH-1:0] hiReg, loReg;

  logic             start, lastIter, geq, showNew;
  logic [WIDTH-1:0] magA, magB, fixHi, fixLo;
  logic [WIDTH:0]   trial, diff;

  assign start    = (stateReg == IDLE) && bus.isdivE && !bus.annulE;
  assign magA     = (bus.signeddivE && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
  assign magB     = (bus.signeddivE && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;
  assign lastIter = (cntReg == CW'(WIDTH - 1));

  // Shift the next dividend bit into the partial remainder and try subtracting the divisor.
  assign trial = {remReg, quotReg[WIDTH-1]};
  assign diff  = trial - {1'b0, divisorReg};
  assign geq   = !diff[WIDTH];

  // Divide-by-zero results are loaded raw at start and bypass the sign fix-up.
  assign fixLo = (!zeroReg && signedReg && (negAReg ^ negBReg)) ? -quotReg : quotReg;
  assign fixHi = (!zeroReg && signedReg && negAReg) ? -remReg : remReg;

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (start) stateNext = (bus.srcbE == '0) ? DONE : BUSY;
      BUSY: begin
        if (bus.annulE)    stateNext = IDLE;
        else if (lastIter) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= IDLE;
      cntReg     <= '0;
      signedReg  <= 1'b0;
      negAReg    <= 1'b0;
      negBReg    <= 1'b0;
      zeroReg    <= 1'b0;
      divisorReg <= '0;
      quotReg    <= '0;
      remReg     <= '0;
      hiReg      <= '0;
      loReg      <= '0;
    end else begin
      stateReg <= stateNext;
      case (stateReg)
        IDLE: begin
          if (start) begin
            signedReg  <= bus.signeddivE;
            negAReg    <= bus.signeddivE && bus.srcaE[WIDTH-1];
            negBReg    <= bus.signeddivE && bus.srcbE[WIDTH-1];
            zeroReg    <= (bus.srcbE == '0);
            divisorReg <= magB;
            cntReg     <= '0;
            if (bus.srcbE == '0) begin
              quotReg <= '1;
              remReg  <= bus.srcaE;
            end else begin
              quotReg <= magA;
              remReg  <= '0;
            end
          end
        end
        BUSY: begin
          if (!bus.annulE) begin
            remReg  <= geq ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            quotReg <= {quotReg[WIDTH-2:0], geq};
            cntReg  <= cntReg + CW'(1);
          end
        end
        DONE: begin
          if (!bus.annulE) begin
            hiReg <= fixHi;
            loReg <= fixLo;
          end
        end
        default: ;
      endcase
    end
  end

  // Results are presented straight from the working registers during DONE so a late annul can still retract them.
  assign showNew       = (stateReg == DONE) && !bus.annulE && !rst;
  assign bus.div_ready = showNew;
  assign bus.div_hi    = showNew ? fixHi : hiReg;
  assign bus.div_lo    = showNew ? fixLo : loReg;
  assign bus.div_stall = !rst && (((stateReg == IDLE) && bus.isdivE && !bus.annulE) ||
                                  (stateReg == BUSY));
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: expected results are queued at start and popped on div_ready.
module tb_div_unit;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  res_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycNow = 0;
  int   lastReadyCyc = 0;

  always @(posedge clk) cycNow <= cycNow + 1;

  function automatic res_t mk(input logic [W-1:0] hi, input logic [W-1:0] lo);
    res_t r;
    r.hi = hi;
    r.lo = lo;
    return r;
  endfunction

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    res_t r;
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      r.lo = '1;
      r.hi = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r.lo = 32'h8000_0000;
      r.hi = '0;
    end else if (sgn) begin
      r.lo = sa / sb;
      r.hi = sa % sb;
    end else begin
      r.lo = a / b;
      r.hi = a % b;
    end
    return r;
  endfunction

  // Starts one divide, follows it to div_ready and compares against the queued expectation.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input res_t expv, input bit hold, input string name);
    int   cyc;
    int   lat;
    res_t e;
    res_t got;
    lat = (b == '0) ? 1 : W + 1;
    @(posedge clk); #1;
    bus.srcaE = a; bus.srcbE = b; bus.signeddivE = sgn;
    bus.isdivE = 1'b1; bus.annulE = 1'b0;
    expQ.push_back(expv);
    cyc = 0;
    @(negedge clk);
    checks++;
    if (bus.div_stall !== 1'b1)
      begin errors++; $display("FAIL %s stall_c0: got %b want 1", name, bus.div_stall); end
    while (bus.div_ready !== 1'b1 && cyc < W + 8) begin
      @(posedge clk); #1;
      if (cyc == 4) begin
        bus.srcaE = $urandom; bus.srcbE = $urandom; bus.signeddivE = ~sgn;
      end
      @(negedge clk);
      cyc++;
      if (bus.div_ready !== 1'b1) begin
        checks++;
        if (bus.div_stall !== 1'b1)
          begin errors++; $display("FAIL %s stall_busy c%0d: got %b want 1", name, cyc, bus.div_stall); end
      end
    end
    checks++;
    if (bus.div_ready !== 1'b1 || cyc != lat)
      begin errors++; $display("FAIL %s latency: got ready=%b at cycle %0d want cycle %0d", name, bus.div_ready, cyc, lat); end
    lastReadyCyc = cycNow;
    checks++;
    if (bus.div_stall !== 1'b0)
      begin errors++; $display("FAIL %s stall_done: got %b want 0", name, bus.div_stall); end
    e = (expQ.size() != 0) ? expQ.pop_front() : expv;
    got.hi = bus.div_hi;
    got.lo = bus.div_lo;
    checks++;
    if (got !== e)
      begin errors++; $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, got.hi, got.lo, e.hi, e.lo); end
    $display("div %-10s a=%h b=%h s=%b -> hi=%h lo=%h (cycle %0d)", name, a, b, sgn, got.hi, got.lo, cyc);
    if (!hold) begin
      bus.isdivE = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.div_ready !== 1'b0 || bus.div_hi !== e.hi || bus.div_lo !== e.lo)
        begin errors++; $display("FAIL %s hold: got ready=%b hi=%h lo=%h want 0 %h %h", name, bus.div_ready, bus.div_hi, bus.div_lo, e.hi, e.lo); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.isdivE = 1'b1; bus.annulE = 1'b0; bus.signeddivE = 1'b0;
    bus.srcaE = 32'd99; bus.srcbE = 32'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.div_stall !== 1'b0 || bus.div_ready !== 1'b0 || bus.div_hi !== '0 || bus.div_lo !== '0)
      begin errors++; $display("FAIL reset_state: got stall=%b ready=%b hi=%h lo=%h want 0 0 0 0", bus.div_stall, bus.div_ready, bus.div_hi, bus.div_lo); end
    @(posedge clk); #1;
    rst = 1'b0; bus.isdivE = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.div_ready !== 1'b0 || bus.div_stall !== 1'b0)
      begin errors++; $display("FAIL reset_release: got ready=%b stall=%b want 0 0", bus.div_ready, bus.div_stall); end
    $display("reset done");
  endtask

  task automatic test_unsigned();
    run_div(32'd7, 32'd2, 1'b0, mk(32'd1, 32'd3), 1'b0, "u7/2");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, mk(32'd1, 32'h7FFF_FFFC), 1'b0, "uF9/2");
    run_div(32'd5, 32'd9, 1'b0, mk(32'd5, 32'd0), 1'b0, "u5/9");
  endtask

  task automatic test_signed();
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD), 1'b0, "s-7/2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, mk(32'd1, 32'hFFFF_FFFD), 1'b0, "s7/-2");
    run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, mk(32'hFFFF_FFFF, 32'd3), 1'b0, "s-7/-2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'd0, 32'h8000_0000), 1'b0, "s_ovf");
  endtask

  task automatic test_div_zero();
    run_div(32'h1234_5678, 32'd0, 1'b0, mk(32'h1234_5678, 32'hFFFF_FFFF), 1'b0, "u_zero");
    run_div(32'h8000_0001, 32'd0, 1'b1, mk(32'h8000_0001, 32'hFFFF_FFFF), 1'b0, "s_zero");
  endtask

  task automatic test_annul();
    res_t prior;
    prior = mk(32'd0, 32'd3);
    run_div(32'd9, 32'd3, 1'b0, prior, 1'b0, "pre_annul");
    // Kill a divide in BUSY cycle 10.
    @(posedge clk); #1;
    bus.srcaE = 32'd1000; bus.srcbE = 32'd3; bus.signeddivE = 1'b0; bus.isdivE = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      bus.isdivE = 1'b0;
      if (k == 10) bus.annulE = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (bus.div_stall !== 1'b1 || bus.div_ready !== 1'b0)
      begin errors++; $display("FAIL annul_c10: got stall=%b ready=%b want 1 0", bus.div_stall, bus.div_ready); end
    @(posedge clk); #1;
    bus.annulE = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.div_stall !== 1'b0)
      begin errors++; $display("FAIL annul_idle: got stall=%b want 0", bus.div_stall); end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if (bus.div_ready !== 1'b0 || bus.div_hi !== prior.hi || bus.div_lo !== prior.lo)
        begin errors++; $display("FAIL annul_quiet: got ready=%b hi=%h lo=%h want 0 %h %h", bus.div_ready, bus.div_hi, bus.div_lo, prior.hi, prior.lo); end
    end
    $display("annul in BUSY done");
    // annulE overrides isdivE in IDLE: a zero-divisor start would pulse ready next cycle.
    @(posedge clk); #1;
    bus.isdivE = 1'b1; bus.annulE = 1'b1; bus.srcbE = '0;
    @(negedge clk);
    checks++;
    if (bus.div_stall !== 1'b0)
      begin errors++; $display("FAIL annul_idle_stall: got %b want 0", bus.div_stall); end
    @(posedge clk); #1;
    bus.isdivE = 1'b0; bus.annulE = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.div_ready !== 1'b0)
      begin errors++; $display("FAIL annul_idle_ready: got %b want 0", bus.div_ready); end
    $display("annul in IDLE done");
    // Reset in cycle 15 of a divide.
    @(posedge clk); #1;
    bus.srcaE = 32'd50; bus.srcbE = 32'd5; bus.isdivE = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      bus.isdivE = 1'b0;
      if (k == 15) rst = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (bus.div_stall !== 1'b0)
      begin errors++; $display("FAIL rst_stall: got %b want 0", bus.div_stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.div_ready !== 1'b0 || bus.div_hi !== '0 || bus.div_lo !== '0 || bus.div_stall !== 1'b0)
      begin errors++; $display("FAIL rst_mid: got ready=%b hi=%h lo=%h stall=%b want all 0", bus.div_ready, bus.div_hi, bus.div_lo, bus.div_stall); end
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      checks++;
      if (bus.div_ready !== 1'b0)
        begin errors++; $display("FAIL rst_quiet: got ready=%b want 0", bus.div_ready); end
    end
    $display("reset mid-divide done");
  endtask

  task automatic test_back_to_back();
    int firstCyc;
    run_div(32'd100, 32'd7, 1'b0, mk(32'd2, 32'd14), 1'b1, "b2b_1");
    firstCyc = lastReadyCyc;
    run_div(32'hFFFF_FFFF, 32'h10, 1'b0, mk(32'hF, 32'h0FFF_FFFF), 1'b0, "b2b_2");
    checks++;
    if (lastReadyCyc - firstCyc != W + 2)
      begin errors++; $display("FAIL b2b_gap: got %0d cycles want %0d", lastReadyCyc - firstCyc, W + 2); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         sgn;
    for (int i = 0; i < 10; i++) begin
      a   = $urandom;
      b   = (i % 3 == 0) ? W'($urandom_range(1, 255)) : $urandom;
      if (i == 7) b = -W'(13);
      sgn = (i % 2 == 1);
      run_div(a, b, sgn, model(a, b, sgn), 1'b0, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_back_to_back();
    test_random();
    checks++;
    if (expQ.size() != 0)
      begin errors++; $display("FAIL scoreboard_left: got %0d entries want 0", expQ.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
